// File: rtl/bsg_vanilla_int_wb_arbiter.sv
// Integer register-file write-port arbiter for the vanilla core: pipeline writeback,
// remote load responses (formatted here) and iterative divider results share one port.
package bsg_vanilla_int_wb_arbiter_pkg;
    localparam int int_data_width_gp     = 32;
    localparam int int_reg_addr_width_gp = 5;

    typedef struct packed {
        logic                             float_wb;
        logic [int_reg_addr_width_gp-1:0] reg_id;
        logic [1:0]                       part_sel;
        logic                             is_byte_op;
        logic                             is_hex_op;
        logic                             is_unsigned_op;
        logic [int_data_width_gp-1:0]     data;
    } remote_load_resp_s;
endpackage

module bsg_vanilla_int_wb_arbiter
    import bsg_vanilla_int_wb_arbiter_pkg::*;
#(
    parameter int data_width_p     = int_data_width_gp,
    parameter int reg_addr_width_p = int_reg_addr_width_gp,
    parameter int starve_limit_p   = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        pipe_wb_v_i,
    input  logic [reg_addr_width_p-1:0] pipe_wb_addr_i,
    input  logic [data_width_p-1:0]     pipe_wb_data_i,

    input  logic                        remote_v_i,
    input  remote_load_resp_s           remote_resp_i,
    output logic                        remote_ready_o,

    input  logic                        idiv_v_i,
    input  logic [reg_addr_width_p-1:0] idiv_addr_i,
    input  logic [data_width_p-1:0]     idiv_data_i,
    output logic                        idiv_yumi_o,

    output logic                        rf_w_v_o,
    output logic [reg_addr_width_p-1:0] rf_w_addr_o,
    output logic [data_width_p-1:0]     rf_w_data_o,

    output logic                        clear_sb_v_o,
    output logic [reg_addr_width_p-1:0] clear_sb_addr_o,

    output logic                        stall_pipe_wb_o
);

    localparam int cnt_w = $clog2(starve_limit_p + 1);
    localparam logic [cnt_w-1:0] limit_c = cnt_w'(starve_limit_p);

    typedef enum logic { RR_REMOTE, RR_IDIV } rr_e;

    // One-entry remote response buffer
    logic                        buf_v_q;
    logic [reg_addr_width_p-1:0] buf_reg_q;
    logic [1:0]                  buf_part_q;
    logic                        buf_byte_q;
    logic                        buf_hex_q;
    logic                        buf_uns_q;
    logic [data_width_p-1:0]     buf_data_q;

    rr_e                         rr_q;
    logic [cnt_w-1:0]            cnt_q;
    logic [cnt_w-1:0]            cnt_next;
    logic                        stall_q;

    logic pipe_sel, remote_req, idiv_req;
    logic grant_remote, grant_idiv, np_grant;
    logic [7:0]              byte_sel;
    logic [15:0]             hex_sel;
    logic [data_width_p-1:0] remote_data;

    // Every request is masked during reset so all outputs read 0 while it is held.
    assign pipe_sel   = pipe_wb_v_i & ~reset_i;
    assign remote_req = buf_v_q     & ~reset_i;
    assign idiv_req   = idiv_v_i    & ~reset_i;

    always_comb begin
        grant_remote = 1'b0;
        grant_idiv   = 1'b0;
        if (!pipe_sel) begin
            if (remote_req && idiv_req) begin
                grant_remote = (rr_q == RR_REMOTE);
                grant_idiv   = (rr_q == RR_IDIV);
            end else begin
                grant_remote = remote_req;
                grant_idiv   = idiv_req;
            end
        end
    end

    assign np_grant       = grant_remote | grant_idiv;
    assign remote_ready_o = ~reset_i & (~buf_v_q | grant_remote);
    assign idiv_yumi_o    = grant_idiv;
    assign stall_pipe_wb_o = stall_q & ~reset_i;

    // Load formatting happens at drain time, from the buffered copy.
    always_comb begin
        byte_sel = buf_data_q[{buf_part_q, 3'b000} +: 8];
        hex_sel  = buf_data_q[{buf_part_q[1], 4'b0000} +: 16];
        if (buf_byte_q)
            remote_data = {{(data_width_p-8){byte_sel[7] & ~buf_uns_q}}, byte_sel};
        else if (buf_hex_q)
            remote_data = {{(data_width_p-16){hex_sel[15] & ~buf_uns_q}}, hex_sel};
        else
            remote_data = buf_data_q;
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        rf_w_v_o        = 1'b0;
        rf_w_addr_o     = '0;
        rf_w_data_o     = '0;
        clear_sb_v_o    = 1'b0;
        clear_sb_addr_o = '0;
        if (pipe_sel) begin
            rf_w_v_o    = (pipe_wb_addr_i != '0);
            rf_w_addr_o = pipe_wb_addr_i;
            rf_w_data_o = pipe_wb_data_i;
        end else if (grant_remote) begin
            rf_w_v_o        = (buf_reg_q != '0);
            rf_w_addr_o     = buf_reg_q;
            rf_w_data_o     = remote_data;
            clear_sb_v_o    = 1'b1;
            clear_sb_addr_o = buf_reg_q;
        end else if (grant_idiv) begin
            rf_w_v_o        = (idiv_addr_i != '0);
            rf_w_addr_o     = idiv_addr_i;
            rf_w_data_o     = idiv_data_i;
            clear_sb_v_o    = 1'b1;
            clear_sb_addr_o = idiv_addr_i;
        end
    end

    always_comb begin
        cnt_next = cnt_q;
        if (np_grant)
            cnt_next = '0;
        else if (remote_req || idiv_req)
            cnt_next = (cnt_q == limit_c) ? cnt_q : cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_v_q <= 1'b0;
            rr_q    <= RR_REMOTE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            if (remote_ready_o)
                buf_v_q <= remote_v_i;
            if (grant_remote)
                rr_q <= RR_IDIV;
            else if (grant_idiv)
                rr_q <= RR_REMOTE;
            cnt_q   <= cnt_next;
            stall_q <= (cnt_next >= limit_c);
        end
    end

    // NOTE: buffer payload is not reset; buf_v_q alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (remote_v_i && remote_ready_o) begin
            buf_reg_q  <= remote_resp_i.reg_id;
            buf_part_q <= remote_resp_i.part_sel;
            buf_byte_q <= remote_resp_i.is_byte_op;
            buf_hex_q  <= remote_resp_i.is_hex_op;
            buf_uns_q  <= remote_resp_i.is_unsigned_op;
            buf_data_q <= remote_resp_i.data;
        end
    end

    a_pipe_honours_stall: assert property (@(posedge clk_i) disable iff (reset_i)
        stall_pipe_wb_o |-> !pipe_wb_v_i);
    a_no_float_remote: assert property (@(posedge clk_i) disable iff (reset_i)
        remote_v_i |-> !remote_resp_i.float_wb);
    a_idiv_hold: assert property (@(posedge clk_i) disable iff (reset_i)
        (idiv_v_i && !idiv_yumi_o) |=> (idiv_v_i && $stable(idiv_addr_i) && $stable(idiv_data_i)));

endmodule

// File: tb/tb_bsg_vanilla_int_wb_arbiter.sv
// Directed self-checking bench for bsg_vanilla_int_wb_arbiter with hand-computed expectations.
module tb_bsg_vanilla_int_wb_arbiter;
    import bsg_vanilla_int_wb_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              pipe_wb_v_i;
    logic [4:0]        pipe_wb_addr_i;
    logic [31:0]       pipe_wb_data_i;
    logic              remote_v_i;
    remote_load_resp_s remote_resp_i;
    logic              remote_ready_o;
    logic              idiv_v_i;
    logic [4:0]        idiv_addr_i;
    logic [31:0]       idiv_data_i;
    logic              idiv_yumi_o;
    logic              rf_w_v_o;
    logic [4:0]        rf_w_addr_o;
    logic [31:0]       rf_w_data_o;
    logic              clear_sb_v_o;
    logic [4:0]        clear_sb_addr_o;
    logic              stall_pipe_wb_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bsg_vanilla_int_wb_arbiter #(
        .data_width_p(32), .reg_addr_width_p(5), .starve_limit_p(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .pipe_wb_v_i(pipe_wb_v_i), .pipe_wb_addr_i(pipe_wb_addr_i), .pipe_wb_data_i(pipe_wb_data_i),
        .remote_v_i(remote_v_i), .remote_resp_i(remote_resp_i), .remote_ready_o(remote_ready_o),
        .idiv_v_i(idiv_v_i), .idiv_addr_i(idiv_addr_i), .idiv_data_i(idiv_data_i),
        .idiv_yumi_o(idiv_yumi_o),
        .rf_w_v_o(rf_w_v_o), .rf_w_addr_o(rf_w_addr_o), .rf_w_data_o(rf_w_data_o),
        .clear_sb_v_o(clear_sb_v_o), .clear_sb_addr_o(clear_sb_addr_o),
        .stall_pipe_wb_o(stall_pipe_wb_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled on the falling edge; inputs change just after the rising edge.
    task automatic sample;
        @(negedge clk);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic remote_load_resp_s mk(input logic [4:0] id, input logic [1:0] part,
                                             input logic is_b, input logic is_h,
                                             input logic is_u, input logic [31:0] d);
        remote_load_resp_s r;
        r.float_wb       = 1'b0;
        r.reg_id         = id;
        r.part_sel       = part;
        r.is_byte_op     = is_b;
        r.is_hex_op      = is_h;
        r.is_unsigned_op = is_u;
        r.data           = d;
        return r;
    endfunction

    task automatic check_write(input string tag, input logic v, input logic [4:0] a,
                               input logic [31:0] d, input logic sb);
        check({tag, "_v"}, 32'(rf_w_v_o), 32'(v));
        check({tag, "_addr"}, 32'(rf_w_addr_o), 32'(a));
        check({tag, "_data"}, rf_w_data_o, d);
        check({tag, "_sb_v"}, 32'(clear_sb_v_o), 32'(sb));
        if (sb) check({tag, "_sb_addr"}, 32'(clear_sb_addr_o), 32'(a));
    endtask

    initial begin
        reset_i        = 1'b1;
        pipe_wb_v_i    = 1'b0;
        pipe_wb_addr_i = '0;
        pipe_wb_data_i = '0;
        remote_v_i     = 1'b0;
        remote_resp_i  = mk(5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        idiv_v_i       = 1'b0;
        idiv_addr_i    = '0;
        idiv_data_i    = '0;

        // Reset state
        step(); step();
        sample();
        check("rst_ready", 32'(remote_ready_o), 32'd0);
        check("rst_wv", 32'(rf_w_v_o), 32'd0);
        check("rst_stall", 32'(stall_pipe_wb_o), 32'd0);
        check("rst_sb", 32'(clear_sb_v_o), 32'd0);
        step();
        reset_i = 1'b0;
        sample();
        check("post_rst_ready", 32'(remote_ready_o), 32'd1);

        // Remote loads back to back: byte signed, byte unsigned, hex signed, word
        step();
        remote_v_i    = 1'b1;
        remote_resp_i = mk(5'd5, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0080_0000);
        sample();
        check("rb_accept_ready", 32'(remote_ready_o), 32'd1);
        check("rb_accept_nowrite", 32'(rf_w_v_o), 32'd0);
        step();
        remote_resp_i = mk(5'd6, 2'd2, 1'b1, 1'b0, 1'b1, 32'h0080_0000);
        sample();
        check_write("byte_signed", 1'b1, 5'd5, 32'hFFFF_FF80, 1'b1);
        check("b2b_ready", 32'(remote_ready_o), 32'd1);
        step();
        remote_resp_i = mk(5'd7, 2'b10, 1'b0, 1'b1, 1'b0, 32'h8001_1234);
        sample();
        check_write("byte_unsigned", 1'b1, 5'd6, 32'h0000_0080, 1'b1);
        step();
        remote_resp_i = mk(5'd8, 2'd0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
        sample();
        check_write("hex_signed", 1'b1, 5'd7, 32'hFFFF_8001, 1'b1);
        step();
        remote_v_i = 1'b0;
        sample();
        check_write("word", 1'b1, 5'd8, 32'h1234_5678, 1'b1);
        step();
        sample();
        check("remote_idle", 32'(rf_w_v_o), 32'd0);

        // Pipeline priority over a full buffer and a pending divider result
        remote_v_i    = 1'b1;
        remote_resp_i = mk(5'd9, 2'd0, 1'b0, 1'b0, 1'b0, 32'hAAAA_5555);
        step();
        pipe_wb_v_i    = 1'b1;
        pipe_wb_addr_i = 5'd3;
        pipe_wb_data_i = 32'hDEAD_BEEF;
        remote_resp_i  = mk(5'd10, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D);
        idiv_v_i       = 1'b1;
        idiv_addr_i    = 5'd11;
        idiv_data_i    = 32'h0000_0011;
        sample();
        check_write("pipe_prio", 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
        check("pipe_prio_ready", 32'(remote_ready_o), 32'd0);
        check("pipe_prio_yumi", 32'(idiv_yumi_o), 32'd0);

        // Round robin: last non-pipeline grant was remote, so idiv goes first
        step();
        pipe_wb_v_i = 1'b0;
        remote_v_i  = 1'b0;
        sample();
        check("rr1_yumi", 32'(idiv_yumi_o), 32'd1);
        check_write("rr1_idiv", 1'b1, 5'd11, 32'h0000_0011, 1'b1);
        check("rr1_ready", 32'(remote_ready_o), 32'd0);
        step();
        idiv_addr_i   = 5'd12;
        idiv_data_i   = 32'h0000_0022;
        remote_v_i    = 1'b1;
        remote_resp_i = mk(5'd13, 2'd0, 1'b0, 1'b1, 1'b1, 32'h0000_F00F);
        sample();
        check("rr2_yumi", 32'(idiv_yumi_o), 32'd0);
        check_write("rr2_remote", 1'b1, 5'd9, 32'hAAAA_5555, 1'b1);
        check("rr2_ready", 32'(remote_ready_o), 32'd1);
        step();
        remote_v_i = 1'b0;
        sample();
        check("rr3_yumi", 32'(idiv_yumi_o), 32'd1);
        check_write("rr3_idiv", 1'b1, 5'd12, 32'h0000_0022, 1'b1);
        step();
        idiv_v_i = 1'b0;
        sample();
        check_write("rr4_remote_hex_u", 1'b1, 5'd13, 32'h0000_F00F, 1'b1);
        check("rr4_stall", 32'(stall_pipe_wb_o), 32'd0);

        // Starvation: idiv denied for four cycles raises the stall in the fifth
        step();
        pipe_wb_v_i    = 1'b1;
        pipe_wb_addr_i = 5'd1;
        idiv_v_i       = 1'b1;
        idiv_addr_i    = 5'd14;
        idiv_data_i    = 32'h0000_0077;
        for (int i = 0; i < 4; i++) begin
            pipe_wb_data_i = 32'(i);
            sample();
            check($sformatf("starve_stall_c%0d", i), 32'(stall_pipe_wb_o), 32'd0);
            check($sformatf("starve_yumi_c%0d", i), 32'(idiv_yumi_o), 32'd0);
            step();
        end
        pipe_wb_v_i = 1'b0;
        sample();
        check("starve_stall_c4", 32'(stall_pipe_wb_o), 32'd1);
        check("starve_yumi_c4", 32'(idiv_yumi_o), 32'd1);
        check_write("starve_write", 1'b1, 5'd14, 32'h0000_0077, 1'b1);
        step();
        idiv_v_i = 1'b0;
        sample();
        check("starve_stall_drop", 32'(stall_pipe_wb_o), 32'd0);

        // idiv write to x0: consumed and clears the scoreboard, no register write
        step();
        idiv_v_i    = 1'b1;
        idiv_addr_i = 5'd0;
        idiv_data_i = 32'h0000_0099;
        sample();
        check("x0_yumi", 32'(idiv_yumi_o), 32'd1);
        check_write("x0_idiv", 1'b0, 5'd0, 32'h0000_0099, 1'b1);
        step();
        idiv_v_i = 1'b0;

        // Reset with the buffer full discards the response
        remote_v_i    = 1'b1;
        remote_resp_i = mk(5'd15, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0005);
        step();
        remote_v_i     = 1'b0;
        reset_i        = 1'b1;
        pipe_wb_v_i    = 1'b1;
        pipe_wb_addr_i = 5'd2;
        pipe_wb_data_i = 32'h0000_0042;
        sample();
        check("midrst_wv", 32'(rf_w_v_o), 32'd0);
        check("midrst_ready", 32'(remote_ready_o), 32'd0);
        check("midrst_sb", 32'(clear_sb_v_o), 32'd0);
        step();
        reset_i     = 1'b0;
        pipe_wb_v_i = 1'b0;
        sample();
        check("postrst_wv", 32'(rf_w_v_o), 32'd0);
        check("postrst_sb", 32'(clear_sb_v_o), 32'd0);
        check("postrst_ready", 32'(remote_ready_o), 32'd1);

        // Pointer favours remote after reset
        step();
        remote_v_i    = 1'b1;
        remote_resp_i = mk(5'd16, 2'd0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0000);
        step();
        remote_v_i  = 1'b0;
        idiv_v_i    = 1'b1;
        idiv_addr_i = 5'd17;
        idiv_data_i = 32'h0000_0033;
        sample();
        check("rrrst_yumi", 32'(idiv_yumi_o), 32'd0);
        check_write("rrrst_remote", 1'b1, 5'd16, 32'hCAFE_0000, 1'b1);
        step();
        sample();
        check("rrrst_yumi2", 32'(idiv_yumi_o), 32'd1);
        check_write("rrrst_idiv", 1'b1, 5'd17, 32'h0000_0033, 1'b1);
        step();
        idiv_v_i = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
